seq_cla_adder: RTL and testbench
================================

SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; a multiple of CHUNK, at least CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4: bits summed per cycle by one carry-lookahead slice.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and mode valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operation.
REQ-007 SHALL have port a, input, WIDTH: first operand.
REQ-008 SHALL have port b, input, WIDTH: second operand.
REQ-009 SHALL have port sub, input, 1: 0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid, output, 1: result fields valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port carry_out, output, 1: carry out of the MSB (for sub, 1 = no borrow).
REQ-014 SHALL have port overflow, output, 1: two's-complement signed overflow.
REQ-015 SHALL have port zero, output, 1: sum equals 0.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 SHALL drive in_ready high only in IDLE.
REQ-018 SHALL accept on in_valid&&in_ready: latch a, latch b (bitwise inverted if sub), set carry register = sub, chunk index = 0, go BUSY.
REQ-019 SHALL, each BUSY cycle, sum chunk [idx*CHUNK +: CHUNK] with the carry register, write that result slice, update the carry and increment idx.
REQ-020 SHALL leave BUSY for DONE after processing chunk WIDTH/CHUNK-1.
REQ-021 SHALL assert out_valid exactly WIDTH/CHUNK cycles after the accepting edge (4 for defaults).
REQ-022 SHALL hold out_valid and all result fields stable in DONE until out_valid&&out_ready, then go IDLE.
REQ-023 SHALL ignore in_valid outside IDLE; no queuing, and an accept in the same cycle as a result handshake is not allowed.
REQ-024 SHALL compute overflow as the carry into the MSB XOR carry_out, captured during the final chunk.
REQ-025 SHALL make all arithmetic modulo 2^WIDTH and discard nothing but carry_out.
REQ-026 SHALL reject WIDTH%CHUNK!=0 or CHUNK<1 at elaboration.

Reset
REQ-027 SHALL, on rst_n low, immediately enter IDLE: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, zero=1, idx=0, carry register 0.
REQ-028 SHALL abort any in-progress or undelivered operation on reset, with no result produced.

Configuration
REQ-029 SHALL, with SEQ_CLA_SAT_EN defined, replace sum on signed overflow with 0x7F..F (positive overflow) or 0x80..0 (negative overflow); overflow stays asserted and zero reflects the saturated value.
REQ-030 SHALL, without SEQ_CLA_SAT_EN, output the wrapped sum and include no saturation logic.

Structure
REQ-031 SHALL place the FSM state enum and the default WIDTH/CHUNK constants in shared package calc_pkg.
REQ-032 SHALL instantiate combinational sub-module cla_chunk (CHUNK-wide generate/propagate, lookahead carries, sum = p XOR c, carry out).

Verification
REQ-033 SHALL check: defaults, 0x00FF+0x0001 -> sum 0x0100, cout 0, ovf 0, out_valid exactly 4 cycles after accept.
REQ-034 SHALL check: 0xFFFF+0x0001 -> sum 0x0000, cout 1, zero 1, ovf 0.
REQ-035 SHALL check: sub, 0x0005-0x0007 -> sum 0xFFFE, cout 0, ovf 0; 0x0007-0x0005 -> 0x0002, cout 1.
REQ-036 SHALL check: 0x7FFF+0x0001 -> ovf 1, sum 0x8000 (0x7FFF with SEQ_CLA_SAT_EN); 0x8000-0x0001 -> ovf 1, sum 0x7FFF (0x8000 with SEQ_CLA_SAT_EN).
REQ-037 SHALL check: out_ready low for 3 cycles in DONE -> out_valid and sum held, in_ready 0, new in_valid ignored; accept follows the cycle after the handshake.
REQ-038 SHALL check: rst_n pulsed low during BUSY -> outputs at reset values asynchronously, no out_valid afterwards; next operation correct with WIDTH=8, CHUNK=2 (0xAB+0x55 -> 0x00, cout 1, 4-cycle latency).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared FSM state encoding and default geometry for the sequential CLA adder.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/cla_chunk.sv
// One CHUNK-wide carry-lookahead slice; purely combinational, no backpressure.
module cla_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             term;

  // Every carry is a flat sum-of-products of g/p/cin, never chained through c.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i <= CHUNK; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
    end
  end

  assign sum   = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_cla_adder.sv
// Add/sub CHUNK bits per cycle; result valid WIDTH/CHUNK cycles after accept, held until out_ready.
// One op in flight, in_ready only when idle; SEQ_CLA_SAT_EN saturates sum on signed overflow.
module seq_cla_adder
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("seq_cla_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
      $error("seq_cla_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic [WIDTH-1:0] sum_out;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  cla_chunk #(
    .CHUNK (CHUNK)
  ) u_cla_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_BUSY;
      ST_BUSY: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b once at accept and seed the carry with 1.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      idx_d   = '0;
    end else if (state_q == ST_BUSY) begin
      sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
      carry_d = chunk_cout;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        cout_d = chunk_cout;
        ovf_d  = chunk_cmsb ^ chunk_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // A wrapped MSB of 1 on overflow means the true result was too positive.
  always_comb begin
`ifdef SEQ_CLA_SAT_EN
    if (ovf_q) begin
      sum_out = sum_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sum_out = sum_q;
    end
`else
    sum_out = sum_q;
`endif
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_out;
    carry_out = cout_q;
    overflow  = ovf_q;
    zero      = (sum_out == '0);
  end

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed checks of seq_cla_adder at 16/4 and 8/2 geometries sharing one clock and reset.
module tb_seq_cla_adder;

  logic clk;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, sub16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, or8, sub8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;

  int checks;
  int failures;

  seq_cla_adder u_dut16 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv16), .in_ready (ir16), .a (a16), .b (b16), .sub (sub16),
    .out_valid (ov16), .out_ready (or16), .sum (s16),
    .carry_out (co16), .overflow (of16), .zero (z16)
  );

  seq_cla_adder #(.WIDTH (8), .CHUNK (2)) u_dut8 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv8), .in_ready (ir8), .a (a8), .b (b8), .sub (sub8),
    .out_valid (ov8), .out_ready (or8), .sum (s8),
    .carry_out (co8), .overflow (of8), .zero (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept at the next rising edge, count edges until out_valid, check fields, then handshake.
  task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                      input logic [15:0] es, input logic eco, input logic eof, input logic ez);
    int lat;
    @(negedge clk);
    a16 = ia; b16 = ib; sub16 = isub; iv16 = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, ir16}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_sum"},  {16'd0, s16}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, co16}, {31'd0, eco});
    chk({tag, "_ovf"},  {31'd0, of16}, {31'd0, eof});
    chk({tag, "_zero"}, {31'd0, z16},  {31'd0, ez});
    if (or16) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_released"}, {31'd0, ov16}, 32'd0);
    end
  endtask

  logic [15:0] sat_pos, sat_neg, held;
  logic        saw_valid;
  int          lat8;

  initial begin
    checks = 0; failures = 0;
    iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; or16 = 1;
    iv8 = 0; a8 = 0; b8 = 0; sub8 = 0; or8 = 1;
`ifdef SEQ_CLA_SAT_EN
    sat_pos = 16'h7FFF; sat_neg = 16'h8000;
`else
    sat_pos = 16'h8000; sat_neg = 16'h7FFF;
`endif
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, ir16}, 32'd1);
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_sum",       {16'd0, s16},  32'd0);
    chk("rst_cout",      {31'd0, co16}, 32'd0);
    chk("rst_ovf",       {31'd0, of16}, 32'd0);
    chk("rst_zero",      {31'd0, z16},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    op16("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    op16("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16("sub_5m7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op16("sub_7m5",  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    op16("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, sat_pos,  1'b0, 1'b1, 1'b0);
    op16("ovf_neg",  16'h8000, 16'h0001, 1'b1, sat_neg,  1'b1, 1'b1, 1'b0);

    // Consumer stalls for 3 cycles while a competing request is offered.
    or16 = 1'b0;
    op16("stall", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    held = s16;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'h0F0F; b16 = 16'h0101; sub16 = 1'b0; iv16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", {31'd0, ov16}, 32'd1);
      chk("stall_sum_held",  {16'd0, s16},  {16'd0, held});
      chk("stall_in_ready",  {31'd0, ir16}, 32'd0);
    end
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready",  {31'd0, ir16}, 32'd1);
    chk("post_hs_out_valid", {31'd0, ov16}, 32'd0);
    op16("after_stall", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of BUSY must kill the operation outright.
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  {31'd0, ir16}, 32'd1);
    chk("arst_out_valid", {31'd0, ov16}, 32'd0);
    chk("arst_sum",       {16'd0, s16},  32'd0);
    chk("arst_zero",      {31'd0, z16},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov16) saw_valid = 1'b1;
    end
    chk("arst_no_result", {31'd0, saw_valid}, 32'd0);
    op16("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    // Narrow geometry: 8 bits in 2-bit slices.
    @(negedge clk);
    a8 = 8'hAB; b8 = 8'h55; sub8 = 1'b0; iv8 = 1'b1;
    chk("w8_in_ready", {31'd0, ir8}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat8 = 0;
    while (!ov8 && lat8 < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat8++;
    end
    chk("w8_latency", lat8, 32'd4);
    chk("w8_sum",  {24'd0, s8},  32'h00);
    chk("w8_cout", {31'd0, co8}, 32'd1);
    chk("w8_ovf",  {31'd0, of8}, 32'd0);
    chk("w8_zero", {31'd0, z8},  32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("w8_released", {31'd0, ov8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
